ram8_scan: RTL

Eight-entry, 16-bit register bank that sits directly upstream of the 8-way 16-bit multiplexer stage. It drives that stage's eight data inputs (`q0`–`q7`) and its 3-bit select (`sel`). Words are written by address. A scan sequencer then steps `sel` through the entries under a valid/ready handshake, so a downstream consumer reads the bank one word per accepted beat.

---
 rtl/ram8_scan.sv | 112 +++++++++++
 1 files changed

// File: rtl/ram8_scan.sv
// Eight-entry 16-bit register bank feeding an 8:1 mux, with a handshaked scan sequencer driving sel.
// Writes land one cycle after load is sampled; a sampled start presents entry 0 one cycle later.
// out_ready low freezes sel and the bank; writes arriving while a scan is active are dropped and flagged.
module ram8_scan #(
    parameter int LAST = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    input  logic [2:0]  address,
    input  logic        start,
    input  logic        out_ready,
    output logic [15:0] q0,
    output logic [15:0] q1,
    output logic [15:0] q2,
    output logic [15:0] q3,
    output logic [15:0] q4,
    output logic [15:0] q5,
    output logic [15:0] q6,
    output logic [15:0] q7,
    output logic [2:0]  sel,
    output logic        out_valid,
    output logic        busy,
    output logic        done,
    output logic        wr_drop
);

    localparam logic [2:0] LAST_SEL = 3'(LAST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  sel_nxt;
    logic [15:0] mem [8];

    // Next-state and next-sel: sel only advances on an accepted beat and stops at LAST.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SCAN;
                    sel_nxt   = 3'd0;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    if (sel == LAST_SEL) begin
                        state_nxt = DONE;
                    end else begin
                        sel_nxt = sel + 3'd1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                sel_nxt   = 3'd0;
            end
            default: begin
                state_nxt = IDLE;
                sel_nxt   = 3'd0;
            end
        endcase
    end

    // State register plus registered status outputs, decoded from the next state so they are flop-driven.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sel       <= 3'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_drop   <= 1'b0;
        end else begin
            state     <= state_nxt;
            sel       <= sel_nxt;
            out_valid <= (state_nxt == SCAN);
            busy      <= (state_nxt != IDLE);
            done      <= (state_nxt == DONE);
            wr_drop   <= load && (state != IDLE);
        end
    end

    // Register bank: writes accepted only in IDLE so the presented data is frozen for a whole scan.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                mem[i] <= 16'h0000;
            end
        end else if (load && (state == IDLE)) begin
            mem[address] <= in;
        end
    end

    assign q0 = mem[0];
    assign q1 = mem[1];
    assign q2 = mem[2];
    assign q3 = mem[3];
    assign q4 = mem[4];
    assign q5 = mem[5];
    assign q6 = mem[6];
    assign q7 = mem[7];

endmodule
